// File: rtl/bram_port_master.sv
// rtl/bram_port_master.sv - request/response front end for one port of a read-first block RAM

// Response queue: DEPTH entries of {err, data}, registered output, no bypass.
// A pop frees its slot in the same cycle, so push+pop when full is legal.
module bram_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 257
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  assign valid_o = (count_q != '0);
  // Masked so an empty queue presents zero data rather than stale storage.
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;

  // Next-state for pointers (with explicit wrap for non-power-of-2 depths) and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop_i) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    end
    if (push_i && !pop_i) begin
      count_d = count_q + 1'b1;
    end else if (pop_i && !push_i) begin
      count_d = count_q - 1'b1;
    end
  end

  // Pointer and occupancy registers; reset empties the queue immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Credit gating upstream must make overflow and underflow impossible.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(push_i && !pop_i && count_q == FULL_CNT));
      assert (!(pop_i && count_q == '0));
    end
  end
endmodule

// Top: drives the RAM port combinationally from the accepted request and
// collects read data one cycle later into the credit-gated response queue.
module bram_port_master #(
  parameter int SIZE      = 1024,
  parameter int WIDTH     = 256,
  parameter int RSP_DEPTH = 4,
  parameter int ADDR_W    = $clog2(SIZE) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WIDTH-1:0]  req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_rdata,
  output logic              rsp_err,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [WIDTH-1:0]  bram_di,
  input  logic [WIDTH-1:0]  bram_do
);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam logic [CW-1:0]     CRED_MAX = CW'(RSP_DEPTH);
  localparam logic [ADDR_W-1:0] SIZE_A   = ADDR_W'(SIZE);

  logic [CW-1:0] credits_q, credits_d;
  // rd_pend[0]: in-range read issued last cycle; rd_pend[1]: out-of-range read accepted last cycle.
  logic [1:0]    rd_pend_q, rd_pend_d;

  logic             accept;
  logic             in_range;
  logic             rd_accept;
  logic             rsp_hs;
  logic             fifo_push;
  logic [WIDTH:0]   fifo_push_data;
  logic [WIDTH:0]   fifo_head;

  // Credits cover every read from acceptance until its response handshake,
  // so the queue can never overflow. Writes share the same gate to stay in order.
  assign req_ready = rst_n && (credits_q != '0);
  assign accept    = req_valid && req_ready;
  assign in_range  = (req_addr < SIZE_A);
  assign rd_accept = accept && !req_we;
  assign rsp_hs    = rsp_valid && rsp_ready;

  assign bram_en   = accept && in_range;
  assign bram_we   = bram_en && req_we;
  assign bram_addr = req_addr;
  assign bram_di   = req_wdata;

  // Out-of-range reads bypass the RAM but still take their slot in order.
  assign fifo_push      = rd_pend_q[0] || rd_pend_q[1];
  assign fifo_push_data = rd_pend_q[1] ? {1'b1, {WIDTH{1'b0}}} : {1'b0, bram_do};

  // Credit update: read acceptance consumes, response handshake returns.
  always_comb begin
    credits_d = credits_q;
    case ({rd_accept, rsp_hs})
      2'b10:   credits_d = credits_q - 1'b1;
      2'b01:   credits_d = credits_q + 1'b1;
      default: credits_d = credits_q;
    endcase
  end

  // Read-pending flags mark which kind of read lands in the queue next cycle.
  always_comb begin
    rd_pend_d    = 2'b00;
    rd_pend_d[0] = rd_accept && in_range;
    rd_pend_d[1] = rd_accept && !in_range;
  end

  // Credit counter and pipeline flags; reset drops all in-flight reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits_q <= CRED_MAX;
      rd_pend_q <= 2'b00;
    end else begin
      credits_q <= credits_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  // Credits must stay within 0..RSP_DEPTH.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(rd_accept && !rsp_hs && credits_q == '0));
      assert (!(rsp_hs && !rd_accept && credits_q == CRED_MAX));
    end
  end

  bram_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .W     (WIDTH + 1)
  ) u_rsp_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (fifo_push),
    .push_data_i (fifo_push_data),
    .pop_i       (rsp_hs),
    .valid_o     (rsp_valid),
    .data_o      (fifo_head)
  );

  assign rsp_err   = fifo_head[WIDTH];
  assign rsp_rdata = fifo_head[WIDTH-1:0];
endmodule

// File: tb/tb_bram_port_master.sv
// tb/tb_bram_port_master.sv - directed bench with RAM model and response scoreboard
module tb_bram_port_master;
  localparam int SIZE      = 1024;
  localparam int WIDTH     = 256;
  localparam int RSP_DEPTH = 4;
  localparam int ADDR_W    = $clog2(SIZE) + 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [WIDTH-1:0]  req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WIDTH-1:0]  rsp_rdata;
  logic              rsp_err;
  logic              bram_en;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [WIDTH-1:0]  bram_di;
  logic [WIDTH-1:0]  bram_do;

  int vectors = 0;
  int miscompares = 0;
  int oob_en_cnt = 0;

  logic [WIDTH-1:0] ram  [SIZE];
  logic [WIDTH-1:0] refm [SIZE];
  logic [WIDTH:0]   sb_q [$];

  logic           prev_stall = 1'b0;
  logic [WIDTH:0] prev_rsp;

  always #5 clk = ~clk;

  bram_port_master #(
    .SIZE(SIZE), .WIDTH(WIDTH), .RSP_DEPTH(RSP_DEPTH), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_di(bram_di), .bram_do(bram_do)
  );

  // Read-first single-port RAM model with registered output.
  always @(posedge clk) begin
    if (bram_en) begin
      if (int'(bram_addr) < SIZE) begin
        bram_do <= ram[int'(bram_addr)];
        if (bram_we) ram[int'(bram_addr)] <= bram_di;
      end else begin
        oob_en_cnt <= oob_en_cnt + 1;
      end
    end
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [WIDTH:0] obs, input logic [WIDTH:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: reference memory and expected responses follow accepted requests.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk1("rsp_hold_valid", rsp_valid, 1'b1);
        chkw("rsp_hold_data", {rsp_err, rsp_rdata}, prev_rsp);
      end
      prev_stall = rsp_valid && !rsp_ready;
      prev_rsp   = {rsp_err, rsp_rdata};
      if (rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) chk1("rsp_unexpected", 1'b1, 1'b0);
        else chkw("rsp_data", {rsp_err, rsp_rdata}, sb_q.pop_front());
      end
      if (req_valid && req_ready) begin
        if (req_we) begin
          if (int'(req_addr) < SIZE) refm[int'(req_addr)] = req_wdata;
        end else if (int'(req_addr) < SIZE) begin
          sb_q.push_back({1'b0, refm[int'(req_addr)]});
        end else begin
          sb_q.push_back({1'b1, {WIDTH{1'b0}}});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic drv(input logic v, input logic we, input int a, input logic [WIDTH-1:0] d);
    req_valid = v;
    req_we    = we;
    req_addr  = ADDR_W'(a);
    req_wdata = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    drv(1'b1, 1'b0, 0, '0);

    // Reset held with a pending request
    for (int i = 0; i < 5; i++) begin
      step();
      smp();
      chk1("rst_req_ready", req_ready, 1'b0);
      chk1("rst_bram_en", bram_en, 1'b0);
      chk1("rst_rsp_valid", rsp_valid, 1'b0);
    end
    step();
    rst_n = 1'b1;
    drv(1'b0, 1'b0, 0, '0);
    smp();
    chk1("rel_req_ready", req_ready, 1'b1);
    chkw("rel_rsp", {rsp_err, rsp_rdata}, '0);
    chk1("rel_bram_en", bram_en, 1'b0);

    // Write then read addr 10, latency check
    step();
    drv(1'b1, 1'b1, 10, {32{8'hA5}});
    smp();
    chk1("wr_en", bram_en, 1'b1);
    chk1("wr_we", bram_we, 1'b1);
    step();
    drv(1'b1, 1'b0, 10, '0);
    smp();
    chk1("rd_en", bram_en, 1'b1);
    chk1("rd_we", bram_we, 1'b0);
    step();
    drv(1'b0, 1'b0, 0, '0);
    smp();
    chk1("lat_t1_valid", rsp_valid, 1'b0);
    step();
    smp();
    chk1("lat_t2_valid", rsp_valid, 1'b1);
    chkw("lat_t2_data", {rsp_err, rsp_rdata}, {1'b0, {32{8'hA5}}});
    step();
    smp();
    chk1("single_rsp", rsp_valid, 1'b0);

    // Preload 0..15 with value = addr, plus addr 476 for the out-of-range write check
    for (int i = 0; i < 16; i++) begin
      step();
      drv(1'b1, 1'b1, i, WIDTH'(i));
      smp();
    end
    step();
    drv(1'b1, 1'b1, 476, {WIDTH{1'b1}} ^ WIDTH'(476));
    smp();

    // Streaming reads with rsp_ready held high
    for (int k = 0; k < 18; k++) begin
      step();
      if (k < 16) drv(1'b1, 1'b0, k, '0);
      else drv(1'b0, 1'b0, 0, '0);
      smp();
      if (k < 16) chk1("stream_ready", req_ready, 1'b1);
      if (k >= 2) chk1("stream_rsp_valid", rsp_valid, 1'b1);
    end
    step();
    smp();
    chk1("stream_done", rsp_valid, 1'b0);

    // Backpressure: credits run out after RSP_DEPTH reads
    rsp_ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      step();
      drv(1'b1, 1'b0, 20 + k, '0);
      smp();
      chk1("bp_ready", req_ready, (k < RSP_DEPTH) ? 1'b1 : 1'b0);
    end
    step();
    rsp_ready = 1'b1;
    smp();
    chk1("bp_pop_valid", rsp_valid, 1'b1);
    chk1("bp_pop_ready", req_ready, 1'b0);
    step();
    rsp_ready = 1'b0;
    smp();
    chk1("bp_one_credit", req_ready, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      smp();
      chk1("bp_no_more", req_ready, 1'b0);
    end
    step();
    drv(1'b0, 1'b0, 0, '0);
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) step();
    smp();
    chk1("bp_drained", rsp_valid, 1'b0);

    // Out-of-range read between in-range reads, and an out-of-range write
    step();
    drv(1'b1, 1'b0, 1, '0);
    smp();
    chk1("oor_en_a1", bram_en, 1'b1);
    step();
    drv(1'b1, 1'b0, SIZE, '0);
    smp();
    chk1("oor_en_rd", bram_en, 1'b0);
    step();
    drv(1'b1, 1'b0, 2, '0);
    smp();
    chk1("oor_en_a2", bram_en, 1'b1);
    step();
    drv(1'b1, 1'b1, 1500, {WIDTH{1'b1}});
    smp();
    chk1("oor_wr_en", bram_en, 1'b0);
    chk1("oor_wr_we", bram_we, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      drv(1'b1, 1'b0, (k == 0) ? 476 : k * 5, '0);
      smp();
    end
    step();
    drv(1'b0, 1'b0, 0, '0);
    for (int k = 0; k < 6; k++) step();

    // Reset with three reads queued under backpressure
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      drv(1'b1, 1'b0, 3 + k, '0);
      smp();
    end
    step();
    drv(1'b0, 1'b0, 0, '0);
    rst_n = 1'b0;
    sb_q.delete();
    smp();
    chk1("mid_rst_valid", rsp_valid, 1'b0);
    step();
    rst_n = 1'b1;
    smp();
    chk1("post_rst_valid", rsp_valid, 1'b0);
    chk1("post_rst_ready", req_ready, 1'b1);
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      smp();
      chk1("no_stale_rsp", rsp_valid, 1'b0);
    end
    rsp_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      drv(1'b1, 1'b0, 7 + k, '0);
      smp();
      chk1("post_rst_credits", req_ready, (k < RSP_DEPTH) ? 1'b1 : 1'b0);
    end
    step();
    drv(1'b0, 1'b0, 0, '0);
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) step();
    smp();

    chk1("sb_empty", sb_q.size() == 0, 1'b1);
    chk1("no_oob_ram_access", oob_en_cnt == 0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/bram_port_master.md
# bram_port_master

Request/response front end that drives one port of the team's read-first true-dual-port block RAM. Converts a valid/ready request stream (reads and writes) into the RAM's enable/write-enable/address/data port and returns read data on a valid/ready response stream. It absorbs the RAM's one-cycle registered read latency and downstream backpressure with a credit-gated response FIFO. Placed between a client (DMA engine, lookup pipeline) and port A or B of the RAM.

## Interface
- SIZE, 1024, RAM depth in words; must match the attached RAM.
- WIDTH, 256, data width in bits.
- RSP_DEPTH, 4, response FIFO entries and read credits; legal range 3..16.
- ADDR_W, $clog2(SIZE)+1, address width; matches the RAM port, which carries one extra MSB.

- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when valid && ready.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  WIDTH  write data.
- rsp_valid  out  1  read response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  WIDTH  read data; zero when rsp_err = 1.
- rsp_err  out  1  read address was out of range (>= SIZE).
- bram_en  out  1  to RAM en.
- bram_we  out  1  to RAM we.
- bram_addr  out  ADDR_W  to RAM addr.
- bram_di  out  WIDTH  to RAM di.
- bram_do  in  WIDTH  from RAM do (registered in RAM, valid one cycle after en).

## Operation
- Accept = req_valid && req_ready. Requests are processed strictly in order.
- req_ready = rst_n && (credits > 0). Uniform for reads and writes, so writes cannot overtake stalled reads.
- credits: reset to RSP_DEPTH.
  - -1 on accepted read.
  - +1 on response handshake (rsp_valid && rsp_ready).
  - Both in the same cycle: unchanged.
  - Never exceeds RSP_DEPTH and never goes below 0. A violation is a design bug; flag it with an assertion.
- Port drive is combinational from the accepted request:
  - bram_en = accept && (req_addr < SIZE).
  - bram_we = req_we.
  - bram_addr = req_addr.
  - bram_di = req_wdata.
  - When bram_en = 0, bram_we is forced to 0.
- Writes produce no response. Out-of-range writes are silently dropped.
- In-range read: pipeline flag rd_pend[0] is set for one cycle after issue. In that cycle bram_do is pushed into the FIFO with err = 0.
- Out-of-range read: flag rd_pend[1] is set. One cycle after acceptance, the FIFO receives data = 0 and err = 1. Ordering with in-range reads is preserved, because only one request is accepted per cycle.
- Read-after-write to the same address in consecutive cycles returns the new data, because the RAM write completes before the later read is issued. A read at the same address in the same port cycle is not possible (one request per cycle).
- FIFO: RSP_DEPTH entries of {err, data}.
  - Push and pop in the same cycle are allowed, including when full (pop frees a slot first) and when empty-with-push (no bypass).
  - The credit scheme guarantees no push when full with no pop.

## Timing
- Reset values: req_ready 0 while rst_n low, 1 in the first cycle after release. rsp_valid 0, rsp_rdata 0, rsp_err 0, bram_en 0, bram_we 0, credits RSP_DEPTH, FIFO empty, rd_pend 0.
- Read latency: accepted in cycle T, bram_do valid in T+1, rsp_valid high in T+2 (if the FIFO was empty).
- Throughput: one read per cycle sustained with rsp_ready held high, for RSP_DEPTH >= 3.
- Backpressure: with rsp_ready low, exactly RSP_DEPTH reads are accepted, then req_ready drops in the following cycle.
- rsp_valid, rsp_rdata and rsp_err hold stable while rsp_valid && !rsp_ready.
- Reset mid-operation: all in-flight reads and queued responses are discarded immediately. No response emerges after release. Writes issued to the RAM before reset remain in RAM.

## Test plan
- Reset: hold rst_n low 5 cycles with req_valid = 1 -> req_ready = 0, bram_en = 0, rsp_valid = 0 throughout; req_ready = 1 on the first cycle after release.
- Write/read: write 0xA5..A5 to addr 10, then read addr 10 next cycle -> one response, rsp_rdata = 0xA5..A5, rsp_err = 0, rsp_valid exactly 2 cycles after read acceptance.
- Streaming: 16 back-to-back reads of addrs 0..15 preloaded with value = addr, rsp_ready = 1 -> req_ready never drops; responses 0..15 in order on consecutive cycles.
- Backpressure: rsp_ready = 0, issue reads continuously -> exactly 4 accepted, req_ready = 0 thereafter. Raise rsp_ready for 1 cycle -> one response, then exactly one more read accepted.
- Out of range: read addr 1024 (SIZE = 1024) interleaved between reads of addrs 1 and 2 -> bram_en low for that request; responses in order: data1, {err = 1, data = 0}, data2. A write to addr 1500 leaves all RAM contents unchanged.
- Reset mid-flight: 3 reads queued with rsp_ready = 0, assert rst_n low 1 cycle -> rsp_valid = 0 after release, credits back to 4, no stale responses ever appear.
